// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types, widths and the immediate sign-extension helper for the shift sequencer.
package shift_pkg;

  localparam int DATA_W  = 16;
  localparam int IMM_W   = 8;
  localparam int SHAMT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } shift_state_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_shr1_step.sv
// Single reusable 1-bit right-shift cell; the caller supplies the bit shifted into the MSB.
module shr1_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic              fill,
  output logic [DATA_W-1:0] out
);

  assign out = {fill, in[DATA_W-1:1]};

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multicycle right-shift sequencer: one shr1_step reused shamt times per request.
// Optional SHIFT_ARITH_EN adds the arith port and sign-fill; without it shifts are logical only.
//
// Handshake: start is a request that is taken only when the FSM sits in IDLE (no queueing);
// busy stays high from the cycle after acceptance through the DONE cycle, and done pulses for
// exactly one cycle with result valid in that cycle. result shows work-in-progress while busy.
module shift_seq_ctrl
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               imm8_sel,
  input  logic [SHAMT_W-1:0] shamt,
`ifdef SHIFT_ARITH_EN
  input  logic               arith,
`endif
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output shift_state_t       state_dbg
);

  shift_state_t       state;
  logic [DATA_W-1:0]  op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [SHAMT_W-1:0] cnt;
  logic [DATA_W-1:0]  sreg;
  logic [DATA_W-1:0]  step_out;
  logic               fill;

`ifdef SHIFT_ARITH_EN
  logic arith_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arith_q <= 1'b0;
    end else if (state == IDLE && start) begin
      arith_q <= arith;
    end
  end

  assign fill = arith_q & sreg[DATA_W-1];
`else
  assign fill = 1'b0;
`endif

  shr1_step u_step (
    .in   (sreg),
    .fill (fill),
    .out  (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sreg    <= '0;
      cnt     <= '0;
      op_q    <= '0;
      shamt_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= imm8_sel ? sext_imm(data_in[IMM_W-1:0]) : data_in;
            shamt_q <= shamt;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          sreg <= op_q;
          cnt  <= shamt_q;
          if (shamt_q == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= step_out;
          cnt  <= cnt - SHAMT_W'(1);
          // cnt==1 means this edge applies the final step
          if (cnt == SHAMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign result    = sreg;
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed + random bench for shift_seq_ctrl with a result/latency scoreboard.
module tb_shift_seq_ctrl;
  import shift_pkg::*;

`ifdef SHIFT_ARITH_EN
  localparam bit ARITH_ON = 1'b1;
`else
  localparam bit ARITH_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [15:0]  data_in;
  logic         imm8_sel;
  logic [3:0]   shamt;
  logic         arith;
  logic         busy;
  logic         done;
  logic [15:0]  result;
  shift_state_t state_dbg;

  logic [15:0] exp_q[$];
  int          lat_q[$];
  int          total;
  int          bad;

  shift_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .imm8_sel  (imm8_sel),
    .shamt     (shamt),
`ifdef SHIFT_ARITH_EN
    .arith     (arith),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] d, input logic im,
                                        input logic [3:0] sh, input logic ar);
    logic [15:0] op;
    op = im ? {{8{d[7]}}, d[7:0]} : d;
    if (ar && ARITH_ON) return 16'($signed(op) >>> sh);
    return op >> sh;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one request, waits (bounded) for done, then scores result and latency.
  task automatic run_op(input string tag, input logic [15:0] d, input logic im,
                        input logic [3:0] sh, input logic ar);
    int k;
    @(negedge clk);
    data_in = d; imm8_sel = im; shamt = sh; arith = ar; start = 1'b1;
    exp_q.push_back(model(d, im, sh, ar));
    lat_q.push_back(int'(sh) + 2);
    @(negedge clk);
    start = 1'b0;
    data_in = ~d; shamt = ~sh; imm8_sel = ~im; arith = ~ar;
    k = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp_q.pop_front()));
    check({tag, "_latency"}, 32'(k), 32'(lat_q.pop_front()));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    int dcount;
    logic [15:0] d4[4];
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; data_in = '0; imm8_sel = 1'b0; shamt = '0; arith = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;

    // 1. reset in the middle of a shift
    @(negedge clk);
    data_in = 16'hF000; shamt = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_state_shift", 32'(state_dbg), 32'(SHIFT));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'h0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("mid_rst_no_done", 32'(dcount), 32'd0);

    // 2-4. directed
    run_op("logical", 16'h8001, 1'b0, 4'd4, 1'b0);
    run_op("arith15", 16'h8000, 1'b0, 4'd15, 1'b1);
    run_op("imm8", 16'h12F0, 1'b1, 4'd0, 1'b0);
    run_op("imm8_pos", 16'hAB7C, 1'b1, 4'd3, 1'b1);
    run_op("arith_pos", 16'h7FF0, 1'b0, 4'd1, 1'b1);

    // 5. start pulsed while busy must be ignored
    @(negedge clk);
    data_in = 16'h1234; imm8_sel = 1'b0; shamt = 4'd6; arith = 1'b0; start = 1'b1;
    exp_q.push_back(model(16'h1234, 1'b0, 4'd6, 1'b0));
    lat_q.push_back(8);
    @(negedge clk);
    start = 1'b0;
    k = 1; dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin
        dcount++;
        if (dcount == 1) begin
          check("busy_rej_result", 32'(result), 32'(exp_q.pop_front()));
          check("busy_rej_latency", 32'(k), 32'(lat_q.pop_front()));
        end
      end
      if (k == 3) begin
        start = 1'b1; data_in = 16'hFFFF; shamt = 4'd2;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_rej_one_done", 32'(dcount), 32'd1);
    check("busy_rej_held", 32'(result), 32'h0048);

    // 6. start held high: one operation every 4 cycles with shamt=1
    d4[0] = 16'h8002; d4[1] = 16'h0F0F; d4[2] = 16'hFFFE; d4[3] = 16'h4001;
    imm8_sel = 1'b0; shamt = 4'd1; arith = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk);
      if (n > 0) begin
        check($sformatf("b2b_done_n%0d", n), 32'(done), 32'((n % 4) == 3));
        if (done === 1'b1 && exp_q.size() > 0)
          check($sformatf("b2b_result_n%0d", n), 32'(result), 32'(exp_q.pop_front()));
      end
      if (n < 16 && (n % 4) == 0) begin
        start = 1'b1;
        data_in = d4[n/4];
        exp_q.push_back(model(d4[n/4], 1'b0, 4'd1, 1'b0));
      end else if (n == 16) begin
        start = 1'b0;
      end
    end
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);

    // random traffic
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("rand%0d", i), 16'($urandom_range(0, 16'hFFFF)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
